// File: rtl/mips_pkg.sv
// Shared MIPS-32 core definitions: opcodes, fetch FSM encoding and reset vector.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] J      = 6'h02;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select: jump beats taken branch beats sequential pc_plus4.
module next_pc_calc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  jump,
  input  logic                  branch,
  input  logic                  zero,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [ADDR_WIDTH-1:0] jump_target;
  logic [ADDR_WIDTH-1:0] branch_target;

  // Opcode bits play no part in target arithmetic.
  wire unused_opcode = ^instr[DATA_WIDTH-1:26];

  assign jump_target   = {pc_plus4[ADDR_WIDTH-1:28], instr[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{(ADDR_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter plus IDLE/REQ/WAIT/HOLD fetch sequencer for a variable-latency instruction memory.
// The captured word is held until retired (i_retire with no i_stall); fetch is one request at a time.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_imem_req,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_valid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_instr_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  input  logic                  i_jump,
  input  logic                  i_branch,
  input  logic                  i_zero,
  input  logic                  i_stall,
  input  logic                  i_retire,
  output logic [31:0]           o_retired_cnt
);

  fetch_state_t          state_q;
  fetch_state_t          state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  retire;
  logic                  accept;

  assign o_pc        = pc_q;
  assign o_imem_addr = pc_q;
  assign o_pc_plus4  = pc_q + ADDR_WIDTH'(INSTR_BYTES);

  assign retire = (state_q == HOLD) && i_retire && !i_stall;
  assign accept = (state_q == WAIT) && i_imem_valid;

  next_pc_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_next_pc (
    .pc_plus4(o_pc_plus4),
    .instr   (o_instr),
    .jump    (i_jump),
    .branch  (i_branch),
    .zero    (i_zero),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    o_imem_req = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        o_imem_req = 1'b1;
        state_d    = WAIT;
      end
      WAIT: if (accept) state_d = HOLD;
      HOLD: if (retire) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      o_instr       <= '0;
      o_instr_valid <= 1'b0;
      o_retired_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        o_instr       <= i_imem_rdata;
        o_instr_valid <= 1'b1;
      end
      // o_instr is left as-is on retire; only the valid flag drops until the next capture.
      if (retire) begin
        pc_q          <= next_pc;
        o_instr_valid <= 1'b0;
        o_retired_cnt <= o_retired_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: expected fetch addresses and instruction words go through scoreboard queues.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        i_jump;
  logic        i_branch;
  logic        i_zero;
  logic        i_stall;
  logic        i_retire;
  logic [31:0] o_retired_cnt;

  int          n_pass;
  int          n_total;
  logic [31:0] exp_cnt;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_valid (i_imem_valid),
    .i_imem_rdata (i_imem_rdata),
    .o_instr      (o_instr),
    .o_instr_valid(o_instr_valid),
    .o_pc         (o_pc),
    .o_pc_plus4   (o_pc_plus4),
    .i_jump       (i_jump),
    .i_branch     (i_branch),
    .i_zero       (i_zero),
    .i_stall      (i_stall),
    .i_retire     (i_retire),
    .o_retired_cnt(o_retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Waits for the request, checks it against the scoreboard, then plays memory with the given latency.
  task automatic fetch(input logic [31:0] data, input int lat, output int waited);
    logic [31:0] ea;
    logic [31:0] ei;
    waited = 0;
    while (!o_imem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!o_imem_req) begin
      check("req_timeout", {31'b0, o_imem_req}, 32'd1);
    end else begin
      ea = exp_addr_q.pop_front();
      check("imem_addr", o_imem_addr, ea);
      check("pc", o_pc, ea);
      check("pc_plus4", o_pc_plus4, ea + 32'd4);
      exp_instr_q.push_back(data);
      // Valid during REQ must be ignored.
      i_imem_valid = 1'b1;
      i_imem_rdata = 32'hDEAD_BEEF;
      for (int i = 1; i < lat; i++) begin
        @(negedge clk);
        i_imem_valid = 1'b0;
      end
      @(negedge clk);
      check("valid_in_wait", {31'b0, o_instr_valid}, 32'd0);
      check("req_in_wait", {31'b0, o_imem_req}, 32'd0);
      i_imem_valid = 1'b1;
      i_imem_rdata = data;
      @(negedge clk);
      i_imem_valid = 1'b0;
      i_imem_rdata = 32'hBAD0_BAD0;
      ei = exp_instr_q.pop_front();
      check("instr_valid", {31'b0, o_instr_valid}, 32'd1);
      check("instr", o_instr, ei);
    end
  endtask

  task automatic retire_it(input logic j, input logic b, input logic z, input logic [31:0] nxt);
    i_retire = 1'b1;
    i_jump   = j;
    i_branch = b;
    i_zero   = z;
    @(negedge clk);
    i_retire = 1'b0;
    i_jump   = 1'b0;
    i_branch = 1'b0;
    i_zero   = 1'b0;
    exp_cnt++;
    check("retired_cnt", o_retired_cnt, exp_cnt);
    check("valid_drop", {31'b0, o_instr_valid}, 32'd0);
    exp_addr_q.push_back(nxt);
  endtask

  initial begin
    int w;
    n_pass       = 0;
    n_total      = 0;
    exp_cnt      = 0;
    rst_n        = 1'b0;
    i_imem_valid = 1'b0;
    i_imem_rdata = '0;
    i_jump       = 1'b0;
    i_branch     = 1'b0;
    i_zero       = 1'b0;
    i_stall      = 1'b0;
    i_retire     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Cycle 0: IDLE dead cycle straight after reset.
    check("rst_req", {31'b0, o_imem_req}, 32'd0);
    check("rst_valid", {31'b0, o_instr_valid}, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    check("rst_cnt", o_retired_cnt, 32'd0);
    check("rst_pc", o_pc, 32'd0);

    // ADDI at 0, one-cycle memory: request in cycle 1, valid from cycle 3.
    exp_addr_q.push_back(32'h0000_0000);
    fetch(32'h2009_0005, 1, w);
    check("first_req_cycle", w, 32'd1);
    // Control inputs without retire must not move the PC.
    i_jump = 1'b1; i_branch = 1'b1; i_zero = 1'b1;
    @(negedge clk);
    check("hold_pc", o_pc, 32'h0000_0000);
    check("hold_valid", {31'b0, o_instr_valid}, 32'd1);
    retire_it(1'b0, 1'b0, 1'b0, 32'h0000_0004);

    fetch(32'h0800_0010, 2, w);                        // J 0x10 at pc 4
    retire_it(1'b1, 1'b0, 1'b0, 32'h0000_0040);
    fetch(32'h1000_0003, 1, w);                        // BEQ +3, taken
    retire_it(1'b0, 1'b1, 1'b1, 32'h0000_0050);
    fetch(32'h0800_0010, 3, w);                        // J back to 0x40, with a stall first

    i_retire = 1'b1; i_stall = 1'b1; i_jump = 1'b1;
    i_imem_valid = 1'b1; i_imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_instr", o_instr, 32'h0800_0010);
      check("stall_pc", o_pc, 32'h0000_0050);
      check("stall_valid", {31'b0, o_instr_valid}, 32'd1);
      check("stall_cnt", o_retired_cnt, exp_cnt);
    end
    i_stall = 1'b0;
    i_imem_valid = 1'b0;
    retire_it(1'b1, 1'b0, 1'b0, 32'h0000_0040);

    fetch(32'h1000_0003, 1, w);                        // BEQ not taken
    retire_it(1'b0, 1'b1, 1'b0, 32'h0000_0044);
    fetch(32'h1000_FFEC, 2, w);                        // BEQ -20 words: wraps below zero
    retire_it(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    fetch(32'h8C08_0000, 1, w);                        // LW; zero alone does not branch
    retire_it(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch(32'h2009_0005, 1, w);                        // sequential wrap to 0
    retire_it(1'b0, 1'b0, 1'b0, 32'h0000_0000);
    fetch(32'h1000_FFFD, 1, w);                        // BEQ -3 words from pc 0
    retire_it(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    // Jump with branch+zero also high: jump wins, region bits come from pc_plus4 (0xF).
    fetch(32'h0800_0010, 1, w);
    retire_it(1'b1, 1'b1, 1'b1, 32'hF000_0040);

    // Four-cycle memory, reset dropped in the second WAIT cycle.
    w = 0;
    while (!o_imem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("jump_req_addr", o_imem_addr, exp_addr_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midwait_valid", {31'b0, o_instr_valid}, 32'd0);
    check("midwait_req", {31'b0, o_imem_req}, 32'd0);
    check("midwait_cnt", o_retired_cnt, 32'd0);
    check("midwait_pc", o_pc, 32'h0000_0000);
    @(negedge clk);
    check("post_rst_req", {31'b0, o_imem_req}, 32'd1);
    check("post_rst_addr", o_imem_addr, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main control decoder in the MIPS-32 core.
- Holds the program counter and sequences requests to a synchronous instruction memory with variable latency.
- Presents the captured instruction word, whose [31:26] drives the decoder opcode, and holds it stable until the instruction retires.
- Computes the next PC from the decoder's jump/branch outputs and the ALU zero flag.

Parameters:
- ADDR_WIDTH, 32, PC and instruction-memory address width.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- o_imem_req  out  1  one-cycle read request pulse to instruction memory.
- o_imem_addr  out  ADDR_WIDTH  byte address of the request; always equals o_pc.
- i_imem_valid  in  1  read data valid; sampled only in WAIT.
- i_imem_rdata  in  DATA_WIDTH  instruction word, sampled when i_imem_valid=1 in WAIT.
- o_instr  out  DATA_WIDTH  captured instruction; [31:26] feeds the decoder opcode.
- o_instr_valid  out  1  o_instr is valid and held stable.
- o_pc  out  ADDR_WIDTH  PC of the current instruction.
- o_pc_plus4  out  ADDR_WIDTH  o_pc + 4, modulo 2^32.
- i_jump  in  1  decoder jump control.
- i_branch  in  1  decoder branch control.
- i_zero  in  1  ALU zero flag.
- i_stall  in  1  downstream hold; blocks retirement.
- i_retire  in  1  downstream signals the current instruction has completed.
- o_retired_cnt  out  32  count of retired instructions, wraps modulo 2^32.

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - state=IDLE, pc=RESET_PC, o_instr=0, o_instr_valid=0, o_imem_req=0, o_retired_cnt=0.
  - Reset mid-WAIT or mid-HOLD abandons the instruction; the memory shares the same reset, so no stale response survives.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: outputs quiet; always moves to REQ next cycle, giving one dead cycle after reset release.
- REQ: o_imem_req=1 for exactly one cycle with o_imem_addr=pc; next state WAIT.
- WAIT:
  - o_imem_req=0.
  - On i_imem_valid=1: o_instr<=i_imem_rdata, o_instr_valid<=1, move to HOLD.
  - Otherwise stay in WAIT; there is no timeout.
  - Minimum fetch latency: request in cycle N, data accepted at earliest at edge N+1, o_instr_valid high from cycle N+2.
- HOLD:
  - o_instr, o_pc and o_instr_valid stay stable, so the decoder outputs stay stable.
  - Retire condition is i_retire=1 and i_stall=0.
  - On retire: pc<=next_pc, o_instr_valid<=0, o_retired_cnt increments, state moves to REQ.
  - i_retire while i_stall=1 is ignored and holds.
- next_pc, combinational, evaluated on the retire cycle:
  - If i_jump=1: {pc_plus4[31:28], o_instr[25:0], 2'b00}. Jump has priority over branch.
  - Else if i_branch=1 and i_zero=1: pc_plus4 + ({{14{o_instr[15]}}, o_instr[15:0], 2'b00}), modulo 2^32.
  - Otherwise: pc_plus4.
- Wrap-around: pc=32'hFFFF_FFFC gives pc_plus4=0. Branch targets wrap silently.
- pc[1:0] is always 00; no misalignment is possible.
- i_jump, i_branch and i_zero are ignored outside the retire cycle.
- i_imem_valid outside WAIT is ignored.

Decomposition:
- Shared package mips_pkg:
  - opcode constants R_TYPE, LW, SW, ADDI, BEQ, J.
  - fetch-state encoding IDLE/REQ/WAIT/HOLD (2 bits).
  - RESET_PC default.
  - INSTR_BYTES=4.
- One sub-module: next_pc_calc (combinational). Inputs pc_plus4, instr, jump, branch, zero; output next_pc. Reused by the verification reference model.

Test Plan:
- Reset then memory with 1-cycle latency returning 32'h2009_0005 at addr 0, i_retire pulsed in HOLD -> o_imem_req at cycle 1 with addr 0, o_instr_valid from cycle 3, next request addr 32'h4, o_retired_cnt=1.
- BEQ 32'h1000_0003 at pc 32'h40, i_branch=1, i_zero=1 on retire -> next addr 32'h50. Same case with i_zero=0 -> 32'h44.
- Jump 32'h0800_0010 at pc 32'h8000_0000, i_jump=1 and i_branch=1 together -> next addr 32'h8000_0040 (jump wins).
- i_retire=1 with i_stall=1 for 5 cycles, then i_stall=0 -> o_instr and o_pc unchanged during stall, one retire only, o_retired_cnt increments by 1.
- Memory latency 4 cycles, rst_n=0 asserted in the second WAIT cycle -> o_instr_valid=0, next request addr RESET_PC after the IDLE cycle.
- pc 32'hFFFF_FFFC, non-branch instruction retired -> next request addr 32'h0000_0000.
